// File: rtl/decode_queue.sv
// Instruction buffer between fetch and decode with enqueue-time predecode.
// JAL and (optionally) backward branches redirect fetch ahead of decode.
module decode_queue #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int PREDICT_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fq_valid,
  input  logic [31:0]                fq_insn,
  input  logic [XLEN-1:0]            fq_pc,
  output logic                       fq_stall,
  output logic                       fq_setpc,
  output logic [XLEN-1:0]            fq_newpc,
  input  logic                       flush,
  input  logic                       de_ready,
  output logic                       de_valid,
  output logic [31:0]                de_insn,
  output logic [XLEN-1:0]            de_pc,
  output logic                       de_pred_taken,
  output logic [XLEN-1:0]            de_pred_target,
  output logic                       de_illegal,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     insn_q  [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] tgt_q   [DEPTH];
  logic            taken_q [DEPTH];
  logic            ill_q   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic            enq;
  logic            deq;
  logic            illegal;
  logic            is_jal;
  logic            is_br;
  logic            taken;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] target;

  always_comb begin
    illegal = fq_insn[1:0] != 2'b11;
    is_jal  = fq_insn[6:2] == 5'b11011;
    is_br   = fq_insn[6:2] == 5'b11000;
    j_imm   = {{(XLEN-21){fq_insn[31]}}, fq_insn[31],
               fq_insn[19:12], fq_insn[20],
               fq_insn[30:21], 1'b0};
    b_imm   = {{(XLEN-13){fq_insn[31]}}, fq_insn[31],
               fq_insn[7], fq_insn[30:25],
               fq_insn[11:8], 1'b0};
    // B-imm sign bit set means a backward branch
    taken   = !illegal &&
              (is_jal || (is_br && PREDICT_EN != 0 && fq_insn[31]));
    target  = '0;
    if (taken)
      target = fq_pc + (is_jal ? j_imm : b_imm);
  end

  assign fq_stall = count == CW'(DEPTH);
  assign de_valid = count != '0;
  assign enq      = fq_valid && !fq_stall && !flush && !reset;
  assign deq      = de_valid && de_ready && !flush && !reset;
  assign fq_setpc = enq && taken;
  assign fq_newpc = fq_setpc ? target : '0;
  assign fq_count = count;

  assign de_insn        = insn_q[rd_ptr];
  assign de_pc          = pc_q[rd_ptr];
  assign de_pred_taken  = taken_q[rd_ptr];
  assign de_pred_target = tgt_q[rd_ptr];
  assign de_illegal     = ill_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq) begin
      insn_q[wr_ptr]  <= fq_insn;
      pc_q[wr_ptr]    <= fq_pc;
      tgt_q[wr_ptr]   <= target;
      taken_q[wr_ptr] <= taken;
      ill_q[wr_ptr]   <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= CW'(DEPTH))
        else $error("queue count overflow");
      assert (!deq || count != '0)
        else $error("dequeue from empty queue");
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: fill/drain, streaming, predecode,
// flush, illegal and mid-run reset, plus a PREDICT_EN=0 instance.
module tb_decode_queue;

  logic        clk = 0;
  logic        reset = 1;
  logic        fq_valid = 0;
  logic [31:0] fq_insn = '0;
  logic [31:0] fq_pc = '0;
  logic        flush = 0;
  logic        de_ready = 0;

  logic        fq_stall, fq_setpc, de_valid;
  logic        de_pred_taken, de_illegal;
  logic [31:0] fq_newpc, de_insn, de_pc, de_pred_target;
  logic [2:0]  fq_count;

  logic        n_stall, n_setpc, n_valid;
  logic        n_taken, n_illegal;
  logic [31:0] n_newpc, n_insn, n_pc, n_target;
  logic [2:0]  n_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decode_queue dut (
    .clk(clk), .reset(reset),
    .fq_valid(fq_valid), .fq_insn(fq_insn), .fq_pc(fq_pc),
    .fq_stall(fq_stall), .fq_setpc(fq_setpc),
    .fq_newpc(fq_newpc), .flush(flush),
    .de_ready(de_ready), .de_valid(de_valid),
    .de_insn(de_insn), .de_pc(de_pc),
    .de_pred_taken(de_pred_taken),
    .de_pred_target(de_pred_target),
    .de_illegal(de_illegal), .fq_count(fq_count)
  );

  decode_queue #(.PREDICT_EN(0)) dut_np (
    .clk(clk), .reset(reset),
    .fq_valid(fq_valid), .fq_insn(fq_insn), .fq_pc(fq_pc),
    .fq_stall(n_stall), .fq_setpc(n_setpc),
    .fq_newpc(n_newpc), .flush(flush),
    .de_ready(de_ready), .de_valid(n_valid),
    .de_insn(n_insn), .de_pc(n_pc),
    .de_pred_taken(n_taken),
    .de_pred_target(n_target),
    .de_illegal(n_illegal), .fq_count(n_count)
  );

  // fetch-side assumption: a stalled instruction is held
  logic        held = 0;
  logic [31:0] held_insn = '0;
  always @(posedge clk) begin
    if (held && fq_valid && !flush && !reset)
      assert (fq_insn === held_insn)
        else $error("fetch changed a stalled instruction");
    held      <= fq_valid && fq_stall;
    held_insn <= fq_insn;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nop(input int i);
    return 32'h13 | (i << 20);
  endfunction

  initial begin
    step();
    step();
    reset = 0;
    chk("rst_valid", 32'(de_valid), 0);
    chk("rst_stall", 32'(fq_stall), 0);
    chk("rst_count", 32'(fq_count), 0);
    chk("rst_setpc", 32'(fq_setpc), 0);

    // fill to full, hold the fifth, then drain across the wrap
    for (int i = 0; i < 4; i++) begin
      fq_valid = 1;
      fq_pc    = 32'(i * 4);
      fq_insn  = nop(i);
      step();
    end
    chk("fill_count", 32'(fq_count), 4);
    chk("fill_stall", 32'(fq_stall), 1);
    chk("fill_head", de_pc, 32'h0);
    fq_pc   = 32'h10;
    fq_insn = nop(4);
    step();
    chk("held_count", 32'(fq_count), 4);
    chk("held_stall", 32'(fq_stall), 1);
    de_ready = 1;
    step();
    chk("drain1_count", 32'(fq_count), 3);
    chk("drain1_pc", de_pc, 32'h4);
    chk("drain1_stall", 32'(fq_stall), 0);
    step();
    fq_valid = 0;
    chk("drain2_count", 32'(fq_count), 3);
    chk("drain2_pc", de_pc, 32'h8);
    step();
    chk("drain3_pc", de_pc, 32'hC);
    chk("drain3_count", 32'(fq_count), 2);
    step();
    chk("wrap_pc", de_pc, 32'h10);
    chk("wrap_insn", de_insn, nop(4));
    step();
    chk("drained_valid", 32'(de_valid), 0);
    de_ready = 0;

    // steady stream with occupancy 2
    for (int i = 0; i < 2; i++) begin
      fq_valid = 1;
      fq_pc    = 32'h300 + 32'(i * 4);
      fq_insn  = nop(i);
      step();
    end
    de_ready = 1;
    for (int k = 0; k < 10; k++) begin
      fq_pc   = 32'h308 + 32'(k * 4);
      fq_insn = nop(k + 2);
      chk("stream_head", de_pc, 32'h300 + 32'(k * 4));
      step();
      chk("stream_count", 32'(fq_count), 2);
    end
    fq_valid = 0;
    step();
    step();
    chk("stream_empty", 32'(de_valid), 0);
    de_ready = 0;

    // predecode
    fq_valid = 1;
    fq_pc    = 32'h100;
    fq_insn  = 32'hFE000CE3;
    #1;
    chk("bwd_setpc", 32'(fq_setpc), 1);
    chk("bwd_newpc", fq_newpc, 32'hF8);
    chk("np_bwd_setpc", 32'(n_setpc), 0);
    chk("np_bwd_newpc", n_newpc, 32'h0);
    step();
    chk("bwd_taken", 32'(de_pred_taken), 1);
    chk("bwd_target", de_pred_target, 32'hF8);
    chk("np_bwd_taken", 32'(n_taken), 0);
    fq_pc   = 32'h104;
    fq_insn = 32'h00000463;
    #1;
    chk("fwd_setpc", 32'(fq_setpc), 0);
    chk("fwd_newpc", fq_newpc, 32'h0);
    step();
    fq_pc   = 32'h200;
    fq_insn = 32'h0400006F;
    #1;
    chk("jal_setpc", 32'(fq_setpc), 1);
    chk("jal_newpc", fq_newpc, 32'h240);
    chk("np_jal_newpc", n_newpc, 32'h240);
    step();
    fq_valid = 0;
    de_ready = 1;
    step();
    chk("fwd_taken", 32'(de_pred_taken), 0);
    chk("fwd_target", de_pred_target, 32'h0);
    step();
    chk("jal_taken", 32'(de_pred_taken), 1);
    chk("jal_target", de_pred_target, 32'h240);
    step();
    de_ready = 0;

    // flush with a JAL presented
    for (int i = 0; i < 3; i++) begin
      fq_valid = 1;
      fq_pc    = 32'h400 + 32'(i * 4);
      fq_insn  = nop(i);
      step();
    end
    chk("preflush_count", 32'(fq_count), 3);
    flush   = 1;
    fq_pc   = 32'h200;
    fq_insn = 32'h0400006F;
    #1;
    chk("flush_setpc", 32'(fq_setpc), 0);
    chk("flush_newpc", fq_newpc, 32'h0);
    step();
    flush    = 0;
    fq_valid = 0;
    chk("flush_valid", 32'(de_valid), 0);
    chk("flush_count", 32'(fq_count), 0);
    fq_valid = 1;
    fq_pc    = 32'h500;
    fq_insn  = nop(7);
    step();
    fq_valid = 0;
    chk("postflush_valid", 32'(de_valid), 1);
    chk("postflush_pc", de_pc, 32'h500);
    chk("legal_flag", 32'(de_illegal), 0);
    de_ready = 1;
    step();
    de_ready = 0;

    // illegal encoding
    fq_valid = 1;
    fq_pc    = 32'h600;
    fq_insn  = 32'h0;
    #1;
    chk("ill_setpc", 32'(fq_setpc), 0);
    step();
    fq_valid = 0;
    chk("ill_flag", 32'(de_illegal), 1);
    chk("ill_taken", 32'(de_pred_taken), 0);
    de_ready = 1;
    step();
    de_ready = 0;

    // reset mid-run with a JAL in flight
    for (int i = 0; i < 2; i++) begin
      fq_valid = 1;
      fq_pc    = 32'h700 + 32'(i * 4);
      fq_insn  = nop(i);
      step();
    end
    chk("prerst_count", 32'(fq_count), 2);
    reset   = 1;
    fq_pc   = 32'h200;
    fq_insn = 32'h0400006F;
    #1;
    chk("rst_jal_setpc", 32'(fq_setpc), 0);
    step();
    reset    = 0;
    fq_valid = 0;
    chk("mrst_valid", 32'(de_valid), 0);
    chk("mrst_count", 32'(fq_count), 0);
    chk("mrst_stall", 32'(fq_stall), 0);
    fq_valid = 1;
    fq_pc    = 32'h800;
    fq_insn  = nop(9);
    step();
    fq_valid = 0;
    chk("resume_pc", de_pc, 32'h800);
    chk("resume_count", 32'(fq_count), 1);
    de_ready = 1;
    step();
    chk("resume_empty", 32'(de_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
